// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if : writeback sources, scoreboard alloc and RF write port
// Revision: 1.0
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
);
   logic             alu_valid;
   logic             alu_ready;
   logic [AW-1:0]    alu_rd;
   logic [XLEN-1:0]  alu_wd;
   logic             lsu_valid;
   logic             lsu_ready;
   logic [AW-1:0]    lsu_rd;
   logic [XLEN-1:0]  lsu_wd;
   logic             alloc_valid;
   logic [AW-1:0]    alloc_rd;
   logic             rf_write_enable;
   logic [AW-1:0]    rf_rd;
   logic [XLEN-1:0]  rf_wd;
   logic [NREGS-1:0] pending;
   logic             last_grant;

   modport master (
      output alu_valid, alu_rd, alu_wd,
      output lsu_valid, lsu_rd, lsu_wd,
      output alloc_valid, alloc_rd,
      input  alu_ready, lsu_ready,
      input  rf_write_enable, rf_rd, rf_wd, pending, last_grant
   );

   modport slave (
      input  alu_valid, alu_rd, alu_wd,
      input  lsu_valid, lsu_rd, lsu_wd,
      input  alloc_valid, alloc_rd,
      output alu_ready, lsu_ready,
      output rf_write_enable, rf_rd, rf_wd, pending, last_grant
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wb_arbiter : round-robin ALU/LSU writeback arbiter + pending scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  wire logic               clk,
   input  wire logic               rst,
   regfile_wb_arbiter_if.slave     wb
);
   logic             alu_gnt;
   logic             lsu_gnt;
   logic             xfer;
   logic [AW-1:0]    sel_rd;
   logic [XLEN-1:0]  sel_wd;

   logic             rf_we_q;
   logic [AW-1:0]    rf_rd_q;
   logic [XLEN-1:0]  rf_wd_q;
   logic             last_grant_q;
   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   // last_grant_q = 1 means the LSU won last, so the ALU takes the next tie.
   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (!rst) begin
         if (wb.alu_valid && wb.lsu_valid) begin
            alu_gnt = last_grant_q;
            lsu_gnt = !last_grant_q;
         end else begin
            alu_gnt = wb.alu_valid;
            lsu_gnt = wb.lsu_valid;
         end
      end
   end

   assign xfer   = alu_gnt | lsu_gnt;
   assign sel_rd = lsu_gnt ? wb.lsu_rd : wb.alu_rd;
   assign sel_wd = lsu_gnt ? wb.lsu_wd : wb.alu_wd;

   // Clear is applied before set so a same-edge re-allocation keeps the bit.
   always_comb begin
      pending_d = pending_q;
      if (rf_we_q) begin
         pending_d[rf_rd_q] = 1'b0;
      end
      if (wb.alloc_valid && (wb.alloc_rd != '0)) begin
         pending_d[wb.alloc_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q      <= 1'b0;
         rf_rd_q      <= '0;
         rf_wd_q      <= '0;
         last_grant_q <= 1'b1;
         pending_q    <= '0;
      end else begin
         rf_we_q   <= xfer && (sel_rd != '0);
         pending_q <= pending_d;
         if (xfer) begin
            rf_rd_q      <= sel_rd;
            rf_wd_q      <= sel_wd;
            last_grant_q <= lsu_gnt;
         end
      end
   end

   assign wb.alu_ready       = alu_gnt;
   assign wb.lsu_ready       = lsu_gnt;
   assign wb.rf_write_enable = rf_we_q;
   assign wb.rf_rd           = rf_rd_q;
   assign wb.rf_wd           = rf_wd_q;
   assign wb.pending         = pending_q;
   assign wb.last_grant      = last_grant_q;
endmodule
`default_nettype wire
